// File: rtl/spi_frame_arbiter.sv
// Round-robin arbiter that frames 1..4-byte SPI transfers from two requesters onto one byte engine.
// Optional WAIT timeout with sticky err flag is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_frame_arbiter #(
    parameter int CS_GAP      = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [1:0]  len0,
    input  logic [1:0]  len1,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic        eng_start,
    output logic [7:0]  eng_data,
    input  logic        eng_busy,
    input  logic        eng_finished,
    output logic        sync,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, SETUP, SEND, WAIT, GAP} state_t;

    localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

    state_t      state_r;
    logic        owner_r;
    logic        last_r;
    logic [1:0]  len_r;
    logic [1:0]  byte_cnt_r;
    logic [31:0] data_r;
    logic [7:0]  gap_cnt_r;
    logic        winner_s;
    logic [7:0]  byte_s;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);
    logic [31:0] wait_cnt_r;
`else
    assign err = 1'b0;
`endif

    // Round-robin winner: on contention the port not served last wins.
    always_comb begin
        winner_s = 1'b0;
        if (req0 && req1) begin
            winner_s = ~last_r;
        end else if (req0) begin
            winner_s = 1'b0;
        end else begin
            winner_s = 1'b1;
        end
    end

    // Current byte of the latched frame, byte 0 in the top bits.
    always_comb begin
        byte_s = 8'h00;
        case (byte_cnt_r)
            2'd0:    byte_s = data_r[31:24];
            2'd1:    byte_s = data_r[23:16];
            2'd2:    byte_s = data_r[15:8];
            2'd3:    byte_s = data_r[7:0];
            default: byte_s = 8'h00;
        endcase
    end

    // Frame FSM with registered outputs; async reset raises sync at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            owner_r    <= 1'b0;
            last_r     <= 1'b1;
            len_r      <= 2'd0;
            byte_cnt_r <= 2'd0;
            data_r     <= 32'h0000_0000;
            gap_cnt_r  <= 8'd0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            eng_start  <= 1'b0;
            eng_data   <= 8'h00;
            sync       <= 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
            wait_cnt_r <= 32'd0;
            err        <= 1'b0;
`endif
        end else begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            eng_start <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req0 || req1) begin
                        owner_r    <= winner_s;
                        last_r     <= winner_s;
                        len_r      <= winner_s ? len1 : len0;
                        data_r     <= winner_s ? data1 : data0;
                        gnt0       <= ~winner_s;
                        gnt1       <= winner_s;
                        sync       <= 1'b0;
                        byte_cnt_r <= 2'd0;
                        state_r    <= SETUP;
`ifdef SPI_ARB_TIMEOUT_EN
                        err        <= 1'b0;
`endif
                    end
                end
                SETUP: begin
                    state_r <= SEND;
                end
                SEND: begin
                    if (!eng_busy) begin
                        eng_start <= 1'b1;
                        eng_data  <= byte_s;
                        state_r   <= WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
                        wait_cnt_r <= 32'd0;
`endif
                    end
                end
                WAIT: begin
                    if (eng_finished) begin
                        if (byte_cnt_r == len_r) begin
                            sync      <= 1'b1;
                            done0     <= ~owner_r;
                            done1     <= owner_r;
                            gap_cnt_r <= GAP_LAST;
                            state_r   <= GAP;
                        end else begin
                            byte_cnt_r <= byte_cnt_r + 2'd1;
                            state_r    <= SEND;
                        end
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (wait_cnt_r == TO_LAST) begin
                        // Engine never answered: abandon the frame and flag it.
                        sync      <= 1'b1;
                        done0     <= ~owner_r;
                        done1     <= owner_r;
                        err       <= 1'b1;
                        gap_cnt_r <= GAP_LAST;
                        state_r   <= GAP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 32'd1;
                    end
`endif
                end
                GAP: begin
                    if (gap_cnt_r == 8'd0) begin
                        state_r <= IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - 8'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    sync    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_arbiter.sv
// Directed bench for spi_frame_arbiter: framing, round-robin, engine back-pressure and mid-frame reset.
module tb_spi_frame_arbiter;

    localparam int CS_GAP      = 4;
    localparam int TIMEOUT_CYC = 1024;
    localparam int ENG_LAT     = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [1:0]  len0, len1;
    logic [31:0] data0, data1;
    logic        gnt0, gnt1, done0, done1;
    logic        eng_start;
    logic [7:0]  eng_data;
    logic        eng_busy, eng_finished;
    logic        sync, err;

    logic        hold_busy;
    logic        mdl_en;
    logic        mdl_busy = 1'b0;
    logic        mdl_fin  = 1'b0;
    int          mdl_cnt  = 0;

    int          checks = 0;
    int          errors = 0;
    int          d0_cnt = 0;
    int          d1_cnt = 0;
    int          both_gnt = 0;
    int          both_done = 0;
    logic [7:0]  byte_q[$];
    logic        gnt_q[$];

    int          bad, n, d0s, d1s;
    logic        ok;

    always #5 clk = ~clk;

    assign eng_busy     = mdl_busy | hold_busy;
    assign eng_finished = mdl_fin;

    spi_frame_arbiter #(.CS_GAP(CS_GAP), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .len0(len0), .len1(len1),
        .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .eng_start(eng_start), .eng_data(eng_data),
        .eng_busy(eng_busy), .eng_finished(eng_finished),
        .sync(sync), .err(err)
    );

    // Byte engine model: busy from start, one-cycle finished pulse ENG_LAT cycles later.
    always @(posedge clk) begin
        #1;
        mdl_fin = 1'b0;
        if (!rst_n) begin
            mdl_cnt  = 0;
            mdl_busy = 1'b0;
        end else begin
            if (mdl_cnt != 0) begin
                mdl_cnt = mdl_cnt - 1;
                if (mdl_cnt == 0) begin
                    mdl_fin  = 1'b1;
                    mdl_busy = 1'b0;
                end
            end
            if (eng_start && mdl_en) begin
                mdl_busy = 1'b1;
                mdl_cnt  = ENG_LAT;
            end
        end
    end

    // Monitor: log started bytes, grants and done pulses just after each edge.
    always @(posedge clk) begin
        #1;
        if (eng_start) byte_q.push_back(eng_data);
        if (gnt0) gnt_q.push_back(1'b0);
        if (gnt1) gnt_q.push_back(1'b1);
        if (gnt0 && gnt1) both_gnt = both_gnt + 1;
        if (done0 && done1) both_done = both_done + 1;
        if (done0) d0_cnt = d0_cnt + 1;
        if (done1) d1_cnt = d1_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_done(input logic port, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if ((port == 1'b0 && done0) || (port == 1'b1 && done1)) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; len0 = 2'd0; len1 = 2'd0;
        data0 = 32'h0; data1 = 32'h0; hold_busy = 1'b0; mdl_en = 1'b1;
        repeat (3) step();
        check("rst_sync", 32'(sync), 1);
        check("rst_start", 32'(eng_start), 0);
        check("rst_data", 32'(eng_data), 0);
        check("rst_gnt", 32'({gnt0, gnt1}), 0);
        check("rst_done", 32'({done0, done1}), 0);
        check("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        step();

        // Two-byte frame on port 0, three-cycle start latency.
        byte_q.delete();
        req0 = 1'b1; len0 = 2'd1; data0 = 32'h00F0_0000;
        step();
        check("t1_gnt0", 32'(gnt0), 1);
        check("t1_gnt1", 32'(gnt1), 0);
        check("t1_sync_low", 32'(sync), 0);
        req0 = 1'b0; data0 = 32'hFFFF_FFFF;
        step();
        check("t1_no_start_setup", 32'(eng_start), 0);
        step();
        check("t1_start_lat", 32'(eng_start), 1);
        check("t1_byte0", 32'(eng_data), 32'h00);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (done0) break;
            if (sync !== 1'b0) bad = bad + 1;
        end
        check("t1_done0", 32'(done0), 1);
        check("t1_sync_frame", 32'(bad), 0);
        check("t1_sync_hi", 32'(sync), 1);
        check("t1_starts", 32'(byte_q.size()), 2);
        check("t1_byte1", 32'(byte_q[1]), 32'hF0);
        check("t1_done0_cnt", 32'(d0_cnt), 1);

        // Port 1 requests during GAP; sync stays high CS_GAP GAP cycles plus the IDLE cycle.
        byte_q.delete();
        req1 = 1'b1; len1 = 2'd3; data1 = 32'h0400_FFFF;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (sync === 1'b0) break;
            n = n + 1;
        end
        check("gap_len", 32'(n), CS_GAP + 1);
        check("t3_gnt1", 32'(gnt1), 1);
        req1 = 1'b0; len1 = 2'd0; data1 = 32'hDEAD_BEEF;
        wait_done(1'b1, ok);
        check("t3_done1", 32'(ok), 1);
        check("t3_starts", 32'(byte_q.size()), 4);
        check("t3_b0", 32'(byte_q[0]), 32'h04);
        check("t3_b1", 32'(byte_q[1]), 32'h00);
        check("t3_b2", 32'(byte_q[2]), 32'hFF);
        check("t3_b3", 32'(byte_q[3]), 32'hFF);
        check("t3_done_cnts", 32'({d0_cnt[15:0], d1_cnt[15:0]}), 32'h0001_0001);

        // Engine busy on SEND entry holds the start off for five cycles.
        repeat (8) step();
        byte_q.delete();
        hold_busy = 1'b1; req0 = 1'b1; len0 = 2'd0; data0 = 32'hA500_0000;
        step();
        check("t4_gnt0", 32'(gnt0), 1);
        req0 = 1'b0;
        step();
        bad = 0;
        repeat (5) begin
            step();
            if (eng_start !== 1'b0) bad = bad + 1;
        end
        check("t4_held", 32'(bad), 0);
        hold_busy = 1'b0;
        step();
        check("t4_start", 32'(eng_start), 1);
        check("t4_byte", 32'(eng_data), 32'hA5);
        wait_done(1'b0, ok);
        check("t4_done0", 32'(ok), 1);
        check("t4_single_start", 32'(byte_q.size()), 1);

        // Reset during the second byte kills the frame silently.
        repeat (8) step();
        byte_q.delete();
        req0 = 1'b1; len0 = 2'd3; data0 = 32'h1122_3344;
        step();
        req0 = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (byte_q.size() >= 2) break;
            step();
        end
        check("t5_byte2_started", 32'(byte_q.size()), 2);
        check("t5_sync_low", 32'(sync), 0);
        d0s = d0_cnt;
        rst_n = 1'b0;
        #1;
        check("t5_sync_async", 32'(sync), 1);
        step(); step();
        rst_n = 1'b1;
        repeat (5) step();
        check("t5_no_done", 32'(d0_cnt), 32'(d0s));
        check("t5_sync_idle", 32'(sync), 1);

        // Contention after reset: grants alternate 0,1,0,1.
        gnt_q.delete();
        d0s = d0_cnt; d1s = d1_cnt;
        req0 = 1'b1; req1 = 1'b1; len0 = 2'd0; len1 = 2'd0;
        data0 = 32'h3C00_0000; data1 = 32'hC300_0000;
        for (int i = 0; i < 400; i++) begin
            step();
            if ((d0_cnt - d0s) + (d1_cnt - d1s) >= 4) break;
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (12) step();
        check("rr_count", 32'(gnt_q.size()), 4);
        check("rr_g0", 32'(gnt_q[0]), 0);
        check("rr_g1", 32'(gnt_q[1]), 1);
        check("rr_g2", 32'(gnt_q[2]), 0);
        check("rr_g3", 32'(gnt_q[3]), 1);
        check("rr_done0", 32'(d0_cnt - d0s), 2);
        check("rr_done1", 32'(d1_cnt - d1s), 2);

`ifdef SPI_ARB_TIMEOUT_EN
        // Silent engine: frame aborts after TIMEOUT_CYC WAIT cycles and err sticks until next grant.
        mdl_en = 1'b0;
        req0 = 1'b1; len0 = 2'd0; data0 = 32'h5500_0000;
        step();
        req0 = 1'b0;
        step(); step();
        check("to_start", 32'(eng_start), 1);
        n = 0;
        for (int i = 0; i < TIMEOUT_CYC + 50; i++) begin
            step();
            n = n + 1;
            if (done0) break;
        end
        check("to_cycles", 32'(n), TIMEOUT_CYC);
        check("to_sync", 32'(sync), 1);
        check("to_err", 32'(err), 1);
        mdl_en = 1'b1;
        repeat (8) step();
        check("to_err_sticky", 32'(err), 1);
        req1 = 1'b1; len1 = 2'd0; data1 = 32'h0;
        step();
        req1 = 1'b0;
        check("to_err_clr", 32'(err), 0);
        wait_done(1'b1, ok);
        check("to_next_done", 32'(ok), 1);
`endif

        check("one_gnt", 32'(both_gnt), 0);
        check("one_done", 32'(both_done), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
